// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data-side SRAM bridge: FSM state encodings,
// access-size encodings and the kseg0/kseg1 segment constants.
package data_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Top three address bits selecting the unmapped segments.
  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  // True when the segment is translated by simply clearing the top bits.
  function automatic logic is_unmapped_seg(input logic [2:0] seg);
    return (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
  endfunction

endpackage

// File: rtl/data_addr_map.sv
// Combinational virtual-to-physical translation for kseg0/kseg1.
// Shared with the instruction side; with MAP_EN=0 the address passes through.
module data_addr_map
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned MAP_EN = 1
) (
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o
);

  // kseg0/kseg1 fold onto the low 512 MB; everything else is untouched.
  always_comb begin
    paddr_o = vaddr_i;
    if ((MAP_EN != 0) && is_unmapped_seg(vaddr_i[31:29])) begin
      paddr_o = {3'b000, vaddr_i[28:0]};
    end
  end

endmodule

// File: rtl/data_sram_bridge.sv
// MEM-stage data port responder: turns a single-cycle load/store into a
// registered req / addr_ok / data_ok transaction and stalls the pipeline
// until the access completes.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no transaction; a new MEM access is latched and issued
//   REQ      | data_req high, waiting for addr_ok (fields held stable)
//   WAIT     | request accepted, waiting for data_ok
//   DONE     | cpu_rdata valid; held until the pipeline advances
//   DRAIN    | flushed after accept; swallow the pending data_ok
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_MAP_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  input  logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_e      state_q;
  logic        req_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] paddr;

  data_addr_map #(
    .MAP_EN (ADDR_MAP_EN)
  ) u_addr_map (
    .vaddr_i (cpu_addr),
    .paddr_o (paddr)
  );

  // Transaction FSM with registered bus fields and load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_en && !cpu_flush) begin
            req_q   <= 1'b1;
            wr_q    <= cpu_we;
            size_q  <= cpu_size;
            wstrb_q <= cpu_sel;
            addr_q  <= paddr;
            wdata_q <= cpu_wdata;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (data_addr_ok) begin
            req_q <= 1'b0;
            if (data_data_ok) begin
              if (cpu_flush) begin
                state_q <= ST_IDLE;
              end else begin
                rdata_q <= data_rdata;
                state_q <= ST_DONE;
              end
            end else begin
              state_q <= cpu_flush ? ST_DRAIN : ST_WAIT;
            end
          end else if (cpu_flush) begin
            // Not yet accepted, so the request can simply be withdrawn.
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            if (cpu_flush) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q <= data_rdata;
              state_q <= ST_DONE;
            end
          end else if (cpu_flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (!cpu_stall || cpu_flush) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (data_data_ok) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall the pipeline for any live access that has not yet completed.
  always_comb begin
    stallreq = cpu_en && !cpu_flush && !rst && (state_q != ST_DONE);
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_wstrb = wstrb_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: each task runs one scenario cycle by
// cycle with hand-computed expectations.
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_flush;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_pass;
  int n_total;
  int stall_cnt;

  data_sram_bridge #(.ADDR_MAP_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_we       (cpu_we),
    .cpu_sel      (cpu_sel),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_flush    (cpu_flush),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .stallreq     (stallreq),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_en = 0; cpu_we = 0; cpu_sel = 4'hF; cpu_size = SIZE_W;
    cpu_addr = 0; cpu_wdata = 0; cpu_flush = 0; cpu_stall = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cpu_en = 1;
    #1;
    n_total++;
    if (stallreq !== 1'b0) $display("FAIL reset_stallreq: got %b want 0", stallreq);
    else n_pass++;
    step();
    step();
    rst = 0;
    cpu_en = 0;
    #1;
    n_total++;
    if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, cpu_rdata, stallreq} !== '0)
      $display("FAIL reset_outputs: req=%b wr=%b size=%0d strb=%h addr=%h wdata=%h rdata=%h stall=%b want all 0",
               data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, cpu_rdata, stallreq);
    else n_pass++;
    n_total++;
    if (dut.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
    else n_pass++;
  endtask

  task automatic test_load_zero_wait();
    stall_cnt = 0;
    cpu_en = 1; cpu_we = 0; cpu_sel = 4'hF; cpu_size = SIZE_W; cpu_addr = 32'h8000_0010;
    #1;
    if (stallreq) stall_cnt++;
    step();
    n_total++;
    if ({data_req, data_wr, data_size, data_addr} !== {1'b1, 1'b0, SIZE_W, 32'h0000_0010})
      $display("FAIL load0_req: req=%b wr=%b size=%0d addr=%h want 1 0 2 00000010",
               data_req, data_wr, data_size, data_addr);
    else n_pass++;
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1234_5678;
    #1;
    if (stallreq) stall_cnt++;
    step();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #1;
    if (stallreq) stall_cnt++;
    n_total++;
    if (cpu_rdata !== 32'h1234_5678) $display("FAIL load0_rdata: got %h want 12345678", cpu_rdata);
    else n_pass++;
    n_total++;
    if (data_req !== 1'b0) $display("FAIL load0_req_drop: got %b want 0", data_req);
    else n_pass++;
    n_total++;
    if (stall_cnt != 2) $display("FAIL load0_stall_cycles: got %0d want 2", stall_cnt);
    else n_pass++;
    step();
    cpu_en = 0;
    #1;
    n_total++;
    if (dut.state_q !== ST_IDLE || data_req !== 1'b0)
      $display("FAIL load0_exit: state=%0d req=%b want IDLE 0", dut.state_q, data_req);
    else n_pass++;
  endtask

  task automatic test_flush_before_accept();
    cpu_en = 1; cpu_we = 0; cpu_size = SIZE_W; cpu_addr = 32'h0000_2000;
    step();
    n_total++;
    if (data_req !== 1'b1 || data_addr !== 32'h0000_2000)
      $display("FAIL fba_req: req=%b addr=%h want 1 00002000", data_req, data_addr);
    else n_pass++;
    step();
    cpu_flush = 1;
    #1;
    n_total++;
    if (stallreq !== 1'b0) $display("FAIL fba_stall_on_flush: got %b want 0", stallreq);
    else n_pass++;
    step();
    cpu_flush = 0; cpu_en = 0;
    #1;
    n_total++;
    if (data_req !== 1'b0 || dut.state_q !== ST_IDLE)
      $display("FAIL fba_withdrawn: req=%b state=%0d want 0 IDLE", data_req, dut.state_q);
    else n_pass++;
    data_data_ok = 1; data_rdata = 32'hDEAD_DEAD;
    step();
    data_data_ok = 0;
    step();
    n_total++;
    if (data_req !== 1'b0 || dut.state_q !== ST_IDLE || cpu_rdata !== 32'h1234_5678)
      $display("FAIL fba_idle_ignores_ok: req=%b state=%0d rdata=%h want 0 IDLE 12345678",
               data_req, dut.state_q, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_flush_after_accept();
    cpu_en = 1; cpu_we = 0; cpu_addr = 32'h8000_0040;
    step();
    data_addr_ok = 1;
    step();
    data_addr_ok = 0;
    cpu_flush = 1;
    #1;
    n_total++;
    if (data_req !== 1'b0 || dut.state_q !== ST_WAIT)
      $display("FAIL faa_wait: req=%b state=%0d want 0 WAIT", data_req, dut.state_q);
    else n_pass++;
    step();
    cpu_flush = 0; cpu_addr = 32'hA000_0080;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin data_data_ok = 1; data_rdata = 32'hBAD0_BAD0; end
      #1;
      n_total++;
      if (stallreq !== 1'b1 || data_req !== 1'b0 || dut.state_q !== ST_DRAIN)
        $display("FAIL faa_drain_%0d: stall=%b req=%b state=%0d want 1 0 DRAIN",
                 i, stallreq, data_req, dut.state_q);
      else n_pass++;
      step();
    end
    data_data_ok = 0; data_rdata = 0;
    #1;
    n_total++;
    if (stallreq !== 1'b1 || data_req !== 1'b0 || cpu_rdata !== 32'h1234_5678)
      $display("FAIL faa_discard: stall=%b req=%b rdata=%h want 1 0 12345678",
               stallreq, data_req, cpu_rdata);
    else n_pass++;
    step();
    n_total++;
    if (data_req !== 1'b1 || data_addr !== 32'h0000_0080 || stallreq !== 1'b1)
      $display("FAIL faa_new_req: req=%b addr=%h stall=%b want 1 00000080 1",
               data_req, data_addr, stallreq);
    else n_pass++;
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h0BB0_0CC0;
    step();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #1;
    n_total++;
    if (cpu_rdata !== 32'h0BB0_0CC0 || stallreq !== 1'b0)
      $display("FAIL faa_new_done: rdata=%h stall=%b want 0bb00cc0 0", cpu_rdata, stallreq);
    else n_pass++;
    step();
    cpu_en = 0;
    step();
  endtask

  task automatic test_store_waits();
    stall_cnt = 0;
    cpu_en = 1; cpu_we = 1; cpu_sel = 4'b0011; cpu_size = SIZE_H;
    cpu_addr = 32'hA000_0100; cpu_wdata = 32'h0000_BEEF;
    #1;
    if (stallreq) stall_cnt++;
    step();
    for (int c = 1; c <= 5; c++) begin
      data_addr_ok = (c == 3);
      data_data_ok = (c == 5);
      data_rdata   = (c == 5) ? 32'hCAFE_F00D : 32'h0;
      if (c <= 3) begin
        // A misbehaving source may change wdata; the latched fields must not follow.
        cpu_wdata = 32'hFFFF_0000 + c;
        #1;
        n_total++;
        if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} !==
            {1'b1, 1'b1, SIZE_H, 4'b0011, 32'h0000_0100, 32'h0000_BEEF})
          $display("FAIL store_req_c%0d: req=%b wr=%b size=%0d strb=%b addr=%h wdata=%h want 1 1 1 0011 00000100 0000beef",
                   c, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata);
        else n_pass++;
      end else begin
        #1;
        if (c == 4) begin
          n_total++;
          if (data_req !== 1'b0) $display("FAIL store_req_drop: got %b want 0", data_req);
          else n_pass++;
        end
      end
      if (stallreq) stall_cnt++;
      step();
    end
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #1;
    if (stallreq) stall_cnt++;
    n_total++;
    if (stall_cnt != 6 || dut.state_q !== ST_DONE)
      $display("FAIL store_stall_cycles: got %0d state=%0d want 6 DONE", stall_cnt, dut.state_q);
    else n_pass++;
    step();
    cpu_en = 0; cpu_we = 0; cpu_sel = 4'hF; cpu_size = SIZE_W; cpu_wdata = 0;
    step();
  endtask

  task automatic test_hold_done();
    cpu_en = 1; cpu_addr = 32'h0000_0300;
    step();
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h55AA_33CC;
    step();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    cpu_stall = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin data_data_ok = 1; data_rdata = 32'h9999_9999; end
      else begin data_data_ok = 0; data_rdata = 0; end
      #1;
      n_total++;
      if (cpu_rdata !== 32'h55AA_33CC || data_req !== 1'b0 || stallreq !== 1'b0 || dut.state_q !== ST_DONE)
        $display("FAIL hold_done_%0d: rdata=%h req=%b stall=%b state=%0d want 55aa33cc 0 0 DONE",
                 i, cpu_rdata, data_req, stallreq, dut.state_q);
      else n_pass++;
      step();
    end
    data_data_ok = 0; data_rdata = 0;
    cpu_stall = 0;
    step();
    cpu_en = 0;
    #1;
    n_total++;
    if (dut.state_q !== ST_IDLE || data_req !== 1'b0)
      $display("FAIL hold_exit: state=%0d req=%b want IDLE 0", dut.state_q, data_req);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    cpu_en = 1; cpu_addr = 32'h8000_0020;
    step();
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1111_2222;
    step();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    step();
    cpu_addr = 32'hC000_0044;
    #1;
    n_total++;
    if (dut.state_q !== ST_IDLE || stallreq !== 1'b1)
      $display("FAIL b2b_idle: state=%0d stall=%b want IDLE 1", dut.state_q, stallreq);
    else n_pass++;
    step();
    n_total++;
    if (data_req !== 1'b1 || data_addr !== 32'hC000_0044)
      $display("FAIL b2b_second_req: req=%b addr=%h want 1 c0000044", data_req, data_addr);
    else n_pass++;
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h3333_4444;
    step();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #1;
    n_total++;
    if (cpu_rdata !== 32'h3333_4444) $display("FAIL b2b_rdata: got %h want 33334444", cpu_rdata);
    else n_pass++;
    step();
    cpu_en = 0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    cpu_en = 1; cpu_we = 1; cpu_sel = 4'hF; cpu_size = SIZE_W;
    cpu_addr = 32'h8000_0004; cpu_wdata = 32'h1122_3344;
    step();
    data_addr_ok = 1;
    step();
    data_addr_ok = 0;
    rst = 1;
    #1;
    n_total++;
    if (stallreq !== 1'b0 || dut.state_q !== ST_WAIT)
      $display("FAIL rstw_pre: stall=%b state=%0d want 0 WAIT", stallreq, dut.state_q);
    else n_pass++;
    step();
    rst = 0; cpu_en = 0; cpu_we = 0;
    #1;
    n_total++;
    if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, cpu_rdata, stallreq} !== '0 ||
        dut.state_q !== ST_IDLE)
      $display("FAIL rstw_outputs: req=%b wr=%b size=%0d strb=%h addr=%h wdata=%h rdata=%h stall=%b state=%0d want all 0 IDLE",
               data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, cpu_rdata, stallreq, dut.state_q);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_load_zero_wait();
    test_flush_before_accept();
    test_flush_after_accept();
    test_store_waits();
    test_hold_done();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Responder for the datapath's data-memory port. It accepts the single-cycle MEM-stage access (enable, write, byte select, size, address, write data) and converts it into a registered SRAM-like request/address-ok/data-ok transaction toward the memory system. It drives `stallreq_from_mem` back to the hazard unit until the access completes, then returns the read data. It sits between the datapath's MEM stage and the data-side bus/cache.

## Interface
Parameters:
- `ADDR_MAP_EN`, default 1: 1 = kseg0/kseg1 translation enabled, 0 = address passed through unchanged.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_en` in 1: the MEM stage holds a load/store.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_sel` in 4: byte lane strobes.
- `cpu_size` in 2: 0 = byte, 1 = half, 2 = word.
- `cpu_addr` in 32: virtual address (ALU result).
- `cpu_wdata` in 32: lane-aligned store data.
- `cpu_flush` in 1: MEM stage flushed (exception or eret).
- `cpu_stall` in 1: MEM stage held by the hazard unit.
- `cpu_rdata` out 32: load data; valid in DONE.
- `stallreq` out 1: connects to `stallreq_from_mem`.
- `data_req` out 1: request valid.
- `data_wr` out 1: request is a write.
- `data_size` out 2: request size.
- `data_wstrb` out 4: write strobes.
- `data_addr` out 32: physical address.
- `data_wdata` out 32: write data.
- `data_addr_ok` in 1: request accepted.
- `data_data_ok` in 1: response delivered.
- `data_rdata` in 32: response data, valid with `data_data_ok`.

## Operation
States: IDLE, REQ, WAIT, DONE, DRAIN.

- **IDLE**
  - `cpu_en & ~cpu_flush`: latch `data_*` from `cpu_*` (translated address) and set `data_req=1`. Go to REQ.
- **REQ** (`data_req=1`; fields held stable)
  - `addr_ok & data_ok`: capture rdata, go to DONE.
  - `addr_ok` only: go to WAIT.
  - `cpu_flush & ~addr_ok`: drop `data_req`, go to IDLE. The request is withdrawn.
  - `cpu_flush & addr_ok & ~data_ok`: go to DRAIN.
  - `cpu_flush & addr_ok & data_ok`: go to IDLE.
  - Note: `data_req` deasserts in the cycle after `addr_ok`.
- **WAIT**
  - `data_ok`: capture `data_rdata` into `cpu_rdata`, go to DONE.
  - `cpu_flush & ~data_ok`: go to DRAIN.
  - `cpu_flush & data_ok`: go to IDLE.
- **DONE**
  - `~cpu_stall | cpu_flush`: go to IDLE. The pipeline advances this cycle.
  - Otherwise hold `cpu_rdata`.
- **DRAIN**
  - `data_ok`: discard the data, go to IDLE. No new request is issued while in DRAIN.
- **`stallreq`** (combinational) = `cpu_en & ~cpu_flush & ~rst & (state != DONE)`.
  - It is also high in DRAIN when a new access is already present.
- **Stores**: `data_ok` is still required. `cpu_rdata` is also updated on store completion and is don't-care.
- **Address map** (`ADDR_MAP_EN=1`):
  - `addr[31:29]` equal to `3'b100` or `3'b101`: `data_addr = {3'b000, addr[28:0]}`.
  - Otherwise `data_addr = addr`.
- **Reset**: state IDLE. `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata` and `cpu_rdata` are all 0. `stallreq` is 0.

## Timing
- **Minimum load/store, same-cycle handshake:**
  - Cycle 0: IDLE, `stallreq=1`.
  - Cycle 1: REQ, `data_req=1`, `addr_ok=data_ok=1`.
  - Cycle 2: DONE, `stallreq=0`, `cpu_rdata` valid.
  - Two stall cycles in total.
- **General case**: stall cycles = 1 + (cycles in REQ) + (cycles in WAIT).
- **Back-to-back accesses**: DONE→IDLE, then the next access issues in the following cycle. There is no gap beyond IDLE.
- **At most one outstanding transaction.** `data_addr_ok` is ignored outside REQ. `data_data_ok` is ignored in IDLE and DONE.
- **`rst` mid-transaction**: everything returns to IDLE immediately. The memory side is reset by the same `rst`.

## Structure
- Shared defines file holds:
  - the state encodings;
  - the size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - the kseg0/kseg1 segment constants.
- One sub-module, `data_addr_map`: combinational virtual→physical translation, also reusable on the instruction side.
- Everything else lives in one FSM plus output registers.

## Test plan
- **Load, zero wait**: `cpu_en=1, we=0, addr=0x8000_0010`, memory gives `addr_ok=data_ok=1` in REQ with `rdata=0x1234_5678`.
  - Expect `data_addr=0x0000_0010`.
  - Expect `stallreq` high for 2 cycles.
  - Expect `cpu_rdata=0x1234_5678` in DONE.
- **Store with waits**: `we=1, sel=4'b0011, size=1, addr=0xA000_0100, wdata=0x0000_BEEF`; `addr_ok` after 3 cycles, `data_ok` 2 cycles later.
  - Expect `data_wstrb=0011` and `data_wr=1`.
  - Expect fields stable through REQ.
  - Expect `stallreq` high for 6 cycles.
- **Flush before accept**: `cpu_flush=1` in the 2nd REQ cycle with `addr_ok=0`.
  - Expect `data_req=0` next cycle, state IDLE, no `data_ok` expected.
- **Flush after accept**: flush in WAIT, then a new load arrives; `data_ok` comes 3 cycles later.
  - Expect the old data discarded.
  - Expect the new `data_req` only after DRAIN exits.
  - Expect `stallreq=1` throughout.
- **Hold in DONE**: `cpu_stall=1` for 4 cycles after completion.
  - Expect `cpu_rdata` stable and no re-issue.
  - Expect exit to IDLE when `cpu_stall` drops.
- **Reset mid-WAIT**: `rst=1` for one cycle.
  - Expect all outputs 0 and state IDLE next cycle.
